// File: rtl/lfsr_pkg.sv
// Shared helpers for the Galois LFSR stream generator: the single-step function
// and the parameter-legality check used at elaboration.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 32;

    // One right-shift Galois step; state and taps are zero-extended to 32 bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (state >> 1) ^ (taps & {LFSR_MAX_W{state[0]}});
    endfunction

    function automatic bit lfsr_params_ok(
        input int unsigned           width,
        input logic [LFSR_MAX_W-1:0] taps,
        input logic [LFSR_MAX_W-1:0] seed,
        input int unsigned           stride
    );
        if (width < 3 || width > LFSR_MAX_W) return 1'b0;
        if (taps[width-1] != 1'b1)           return 1'b0;
        if (seed == '0)                      return 1'b0;
        if (stride < 1 || stride > width)    return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Valid/ready stream bundle of the LFSR word source, plus its control inputs.
interface lfsr_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             i_en;
    logic             i_load;
    logic [WIDTH-1:0] i_seed;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_wrap;
    logic [CNT_W-1:0] o_count;
    logic             o_lockup;

    modport master (
        input  i_en, i_load, i_seed, i_ready,
        output o_data, o_valid, o_wrap, o_count, o_lockup
    );

    modport slave (
        output i_en, i_load, i_seed, i_ready,
        input  o_data, o_valid, o_wrap, o_count, o_lockup
    );
endinterface

// File: rtl/lfsr_stride.sv
// Combinational unroll of STRIDE Galois steps, producing one word advance.
module lfsr_stride
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter int unsigned      STRIDE = 1
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] acc;

    always_comb begin
        acc = state_i;
        for (int unsigned i = 0; i < STRIDE; i++) begin
            acc = WIDTH'(lfsr_step(LFSR_MAX_W'(acc), LFSR_MAX_W'(TAPS)));
        end
    end

    assign next_o = acc;

endmodule

// File: rtl/lfsr_stream.sv
// Backpressure-aware Galois LFSR word source with seed load, stride,
// period (wrap) detection and all-zero lockup recovery.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter int unsigned      STRIDE       = 1,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 8'd100,
    parameter int unsigned      CNT_W        = 8
) (
    input  logic          i_clk,
    input  logic          i_nreset,
    lfsr_stream_if.master s
);

    localparam bit PARAMS_OK = lfsr_params_ok(WIDTH, LFSR_MAX_W'(TAPS),
                                              LFSR_MAX_W'(SEED_DEFAULT), STRIDE);

    if (!PARAMS_OK) begin : g_bad_params
        $error("lfsr_stream: illegal WIDTH/TAPS/SEED_DEFAULT/STRIDE combination");
    end

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] stride_next_c;
    logic             advance_c;

    lfsr_stride #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .STRIDE (STRIDE)
    ) u_stride (
        .state_i (r_q),
        .next_o  (stride_next_c)
    );

    assign advance_c = s.i_en && (!valid_q || s.i_ready);

    // Priority: load > zero-state recovery > advance > drain.
    always_comb begin
        r_d      = r_q;
        ref_d    = ref_q;
        valid_d  = valid_q;
        wrap_d   = wrap_q;
        count_d  = count_q;
        lockup_d = 1'b0;
        if (s.i_load) begin
            if (s.i_seed == '0) begin
                r_d      = SEED_DEFAULT;
                lockup_d = 1'b1;
            end else begin
                r_d = s.i_seed;
            end
            ref_d   = r_d;
            valid_d = 1'b0;
            wrap_d  = 1'b0;
            count_d = '0;
        end else if (r_q == '0) begin
            r_d      = SEED_DEFAULT;
            valid_d  = 1'b0;
            lockup_d = 1'b1;
        end else if (advance_c) begin
            r_d     = stride_next_c;
            valid_d = 1'b1;
            wrap_d  = (stride_next_c == ref_q);
            count_d = wrap_q ? CNT_W'(1) : count_q + CNT_W'(1);
        end else if (valid_q && s.i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_q      <= SEED_DEFAULT;
            ref_q    <= SEED_DEFAULT;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            count_q  <= '0;
            lockup_q <= 1'b0;
        end else begin
            r_q      <= r_d;
            ref_q    <= ref_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            count_q  <= count_d;
            lockup_q <= lockup_d;
        end
    end

    assign s.o_data   = r_q;
    assign s.o_valid  = valid_q;
    assign s.o_wrap   = wrap_q;
    assign s.o_count  = count_q;
    assign s.o_lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench for lfsr_stream: a behavioural model queues expected words,
// a monitor pops and compares them on each handshake.
module tb_lfsr_stream;

    localparam int unsigned W     = 8;
    localparam int unsigned CW    = 8;
    localparam logic [7:0]  TAPS  = 8'hB8;
    localparam logic [7:0]  SEED  = 8'd100;

    typedef struct {
        logic [7:0] data;
        logic       wrap;
        logic [7:0] count;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    // Model of the DUT state after the most recent edge.
    logic [7:0] m_r, m_ref, m_count;
    logic       m_valid, m_wrap, m_lock;

    lfsr_stream_if #(.WIDTH(W), .CNT_W(CW)) sif  ();
    lfsr_stream_if #(.WIDTH(W), .CNT_W(CW)) sif2 ();

    lfsr_stream #(.WIDTH(W), .TAPS(TAPS), .STRIDE(1), .SEED_DEFAULT(SEED), .CNT_W(CW)) dut (
        .i_clk    (clk),
        .i_nreset (rst_n),
        .s        (sif)
    );

    lfsr_stream #(.WIDTH(W), .TAPS(TAPS), .STRIDE(2), .SEED_DEFAULT(SEED), .CNT_W(CW)) dut2 (
        .i_clk    (clk),
        .i_nreset (rst_n),
        .s        (sif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // An odd word shifts right and folds the tap mask in; an even word just shifts.
    function automatic logic [7:0] next_word(input logic [7:0] w);
        return w[0] ? ((w >> 1) ^ TAPS) : (w >> 1);
    endfunction

    // Apply one cycle of inputs, predict its effect, then check flags after the edge.
    task automatic drive(input logic en, input logic load, input logic [7:0] seed, input logic ready);
        logic [7:0] nxt;
        sif.i_en    = en;
        sif.i_load  = load;
        sif.i_seed  = seed;
        sif.i_ready = ready;
        m_lock = 1'b0;
        if (load) begin
            m_r     = (seed == 8'd0) ? SEED : seed;
            m_lock  = (seed == 8'd0);
            m_ref   = m_r;
            m_valid = 1'b0;
            m_wrap  = 1'b0;
            m_count = 8'd0;
        end else if (m_r == 8'd0) begin
            m_r     = SEED;
            m_valid = 1'b0;
            m_lock  = 1'b1;
        end else if (en && (!m_valid || ready)) begin
            if (m_valid) sb_q.push_back('{data: m_r, wrap: m_wrap, count: m_count});
            nxt     = next_word(m_r);
            m_count = m_wrap ? 8'd1 : m_count + 8'd1;
            m_wrap  = (nxt == m_ref);
            m_r     = nxt;
            m_valid = 1'b1;
        end else if (m_valid && ready) begin
            sb_q.push_back('{data: m_r, wrap: m_wrap, count: m_count});
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("o_valid", sif.o_valid, m_valid);
        check("o_lockup", sif.o_lockup, m_lock);
    endtask

    // Monitor: every completed handshake consumes the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sif.o_valid === 1'b1 && sif.i_ready === 1'b1 && sif.i_load === 1'b0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got word 0x%0h, want none queued", sif.o_data);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", sif.o_data, e.data);
                    check("sb_wrap", sif.o_wrap, e.wrap);
                    check("sb_count", sif.o_count, e.count);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        sif.i_en    = 1'b0;
        sif.i_load  = 1'b0;
        sif.i_seed  = 8'd0;
        sif.i_ready = 1'b0;
        sif2.i_en   = 1'b0;
        sif2.i_load = 1'b0;
        sif2.i_seed = 8'd0;
        sif2.i_ready = 1'b0;
        m_r = SEED; m_ref = SEED; m_count = 8'd0;
        m_valid = 1'b0; m_wrap = 1'b0; m_lock = 1'b0;

        #12;
        check("rst_data", sif.o_data, 8'h64);
        check("rst_valid", sif.o_valid, 1'b0);
        check("rst_wrap", sif.o_wrap, 1'b0);
        check("rst_count", sif.o_count, 8'd0);
        check("rst_lockup", sif.o_lockup, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First words, with the stride-2 instance running alongside.
        sif2.i_en = 1'b1; sif2.i_ready = 1'b1;
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        check("w1_data", sif.o_data, 8'h32);
        check("w1_count", sif.o_count, 8'd1);
        check("s2_w1_data", sif2.o_data, 8'h19);
        check("s2_w1_count", sif2.o_count, 8'd1);
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        check("w2_data", sif.o_data, 8'h19);
        check("w2_count", sif.o_count, 8'd2);
        check("s2_w2_data", sif2.o_data, 8'h5A);
        check("s2_w2_valid", sif2.o_valid, 1'b1);
        check("s2_w2_flags", {sif2.o_wrap, sif2.o_lockup}, 2'b00);
        sif2.i_en = 1'b0;
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        check("w3_data", sif.o_data, 8'hB4);
        check("w3_count", sif.o_count, 8'd3);

        // Full period: word 255 returns to the seed.
        for (int i = 3; i < 254; i++) drive(1'b1, 1'b0, 8'd0, 1'b1);
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        check("w255_data", sif.o_data, 8'h64);
        check("w255_wrap", sif.o_wrap, 1'b1);
        check("w255_count", sif.o_count, 8'd255);
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        check("w256_data", sif.o_data, 8'h32);
        check("w256_wrap", sif.o_wrap, 1'b0);
        check("w256_count", sif.o_count, 8'd1);

        // Backpressure: word 0x19 must hold for five stalled cycles.
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'd0, 1'b0);
            check("stall_data", sif.o_data, 8'h19);
            check("stall_count", sif.o_count, 8'd2);
            check("stall_wrap", sif.o_wrap, 1'b0);
        end
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        check("unstall_data", sif.o_data, 8'hB4);
        check("unstall_count", sif.o_count, 8'd3);

        // Zero-seed load substitutes the default seed.
        drive(1'b1, 1'b1, 8'd0, 1'b1);
        check("zload_data", sif.o_data, 8'h64);
        check("zload_count", sif.o_count, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        check("zload_next", sif.o_data, 8'h32);

        // Load while FULL with ready high drops the presented word.
        drive(1'b1, 1'b1, 8'hA5, 1'b1);
        check("fload_data", sif.o_data, 8'hA5);
        check("fload_count", sif.o_count, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 1'b1);

        // Upset the state register to zero and expect recovery.
        sif.i_ready = 1'b0;
        force dut.r_q = 8'h00;
        #1;
        release dut.r_q;
        m_r = 8'h00;
        drive(1'b1, 1'b0, 8'd0, 1'b0);
        check("seu_data", sif.o_data, 8'h64);
        drive(1'b1, 1'b0, 8'd0, 1'b1);
        check("seu_next", sif.o_data, 8'h32);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic       en, ld, rdy;
            logic [7:0] sd;
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            ld  = ($urandom_range(0, 29) == 0);
            sd  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            drive(en, ld, sd, rdy);
        end

        // Drain and confirm every expected word was seen.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'd0, 1'b1);
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised Galois LFSR pseudo-random word source with a valid/ready output stream, run-time seed load, multi-step stride per word, period (wrap) detection and all-zero lockup recovery. It sits between the board pins and any consumer that needs a backpressure-aware random stream, such as VGA pattern and noise generators. It supersedes the fixed 8-bit free-running generator. With default parameters it produces the same sequence as that generator (taps 8,6,5,4).

## Interface
Parameters:
- WIDTH, 8: LFSR and data width, 3..32.
- TAPS, 8'hB8: Galois feedback mask, WIDTH bits. TAPS[WIDTH-1] must be 1.
- STRIDE, 1: LFSR steps per output word, 1..WIDTH.
- SEED_DEFAULT, 8'd100: reset and substitute seed. Must be nonzero.
- CNT_W, 8: width of the word counter.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_nreset  in  1  reset, asynchronous assert, active-low.
- i_en  in  1  allows generation of new words.
- i_load  in  1  one-cycle seed-load strobe.
- i_seed  in  WIDTH  seed value, sampled when i_load=1.
- o_data  out  WIDTH  current word, equal to the LFSR state.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  consumer accepts the word.
- o_wrap  out  1  the presented word equals the reference seed. Qualified by o_valid.
- o_count  out  CNT_W  words since the last load or wrap, including the presented word.
- o_lockup  out  1  one-cycle pulse on zero-seed substitution or zero-state recovery.

## Operation
- Single step, right-shift Galois: next = {1'b0, r[WIDTH-1:1]} ^ ({WIDTH{r[0]}} & TAPS).
- One word advance applies the single step STRIDE times, combinationally, within one cycle.
- Reference register ref holds the last loaded seed, or SEED_DEFAULT after reset.
- Priority per cycle: reset > load > zero-state recovery > advance > drain.
- Load (i_load=1):
  - r <= i_seed. If i_seed==0, r <= SEED_DEFAULT and o_lockup pulses.
  - ref takes the same value as r.
  - o_valid <= 0, o_count <= 0, o_wrap <= 0.
  - The presented word is discarded and i_ready is ignored that cycle.
- Zero-state recovery: if r==0 and there is no load, then r <= SEED_DEFAULT, o_valid <= 0 and o_lockup pulses. No word is emitted that cycle.
- Advance condition: i_en && (!o_valid || i_ready). On advance:
  - r <= stride(r), o_valid <= 1.
  - o_wrap <= (stride(r)==ref).
  - o_count <= 1 if the current presented word has o_wrap=1, else o_count+1, modulo 2^CNT_W.
- Drain: !i_en && o_valid && i_ready sets o_valid <= 0. o_data holds its value.
- Stall: o_valid && !i_ready holds o_data, o_wrap and o_count stable regardless of i_en.
- Two states, implicit in o_valid: EMPTY (o_valid=0) and FULL (o_valid=1). Transitions follow the advance and drain rules above.

## Timing
- Reset values: r = SEED_DEFAULT, ref = SEED_DEFAULT, o_valid=0, o_wrap=0, o_count=0, o_lockup=0.
- Latency: i_en rising in EMPTY gives o_valid=1 on the next clock edge.
- Throughput: with i_en=1 and i_ready=1, one word per cycle.
- A handshake completes on an edge where o_valid && i_ready. The next word is presented in the same edge's output; no bubble.
- A load takes effect on the next edge. The first post-load word appears one cycle after that, if i_en=1.
- Reset mid-stream drops any pending word immediately (asynchronous).
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package lfsr_pkg holds:
  - function lfsr_step(state, taps), the single Galois step.
  - localparam checks that fire an error if TAPS[WIDTH-1]==0, SEED_DEFAULT==0, or STRIDE is out of range.
- Sub-module lfsr_stride: combinational unroll of STRIDE lfsr_step calls, parameters WIDTH, TAPS, STRIDE. It is instantiated once.
- The top level holds the r and ref registers, the handshake, the counter and the flags.

## Test plan
All scenarios use defaults unless stated.
- Reset, i_en=1, i_ready=1 -> words 0x32, 0x19, 0xB4 on consecutive cycles; o_count 1, 2, 3.
- Free-run 255 words -> word 255 is 0x64 with o_wrap=1 and o_count=255; the next word is 0x32 with o_count=1 and o_wrap=0.
- STRIDE=2 from reset -> words 0x19, then 0x5A.
- Backpressure:
  - i_ready=0 for 5 cycles with o_valid=1 -> o_data, o_count and o_wrap are stable.
  - Raise i_ready -> the next word follows with no skip.
- i_load with i_seed=0 -> o_lockup pulses once; ref = 0x64; the next word is 0x32.
- Force r=0 via the bench (SEU model) -> recovery to 0x64, o_lockup pulses, o_valid=0 for one cycle.
- i_load asserted together with i_ready while FULL -> the word is dropped and o_count resets to 0.
